limbus_irq_ctrl: RTL and testbench
==================================

Name: limbus_irq_ctrl

Overview:
- Interrupt controller that consumes the irq outputs of the limbus timer and peer peripherals and presents one prioritised interrupt line to the CPU.
- Latches each source as edge- or level-type with a per-source enable mask.
- Provides a claim register that returns the highest-priority pending vector and auto-clears it.
- Exposes a 16-bit Avalon-MM slave with the same read timing as the other limbus peripherals.

Parameters:
- NUM_IRQ, 8, number of interrupt sources; legal range 1..16.
- RST_ENABLE, 16'h0000, reset value of the enable register; bits at and above NUM_IRQ are ignored.
- RST_MODE, 16'h0000, reset value of the mode register; 1 = edge, 0 = level.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq_in  input  NUM_IRQ  interrupt requests, synchronous to clk; bit 0 is highest priority.
- address  input  3  Avalon word address.
- chipselect  input  1  Avalon slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  16  write data.
- readdata  output  16  registered read data.
- irq  output  1  combined interrupt to the CPU.

Behaviour:
- Reset sets: pending = 0, irq_d (previous irq_in) = 0, enable = RST_ENABLE, mode = RST_MODE, readdata = 0, irq = 0.
- Strobes: wr = chipselect && ~write_n; rd = chipselect && write_n.
- Edge source i (mode[i] = 1):
  - rise[i] = irq_in[i] & ~irq_d[i].
  - Set pending[i] on rise[i].
  - Clear pending[i] by a W1C write to address 0 or by a claim.
  - If a set and a clear occur in the same cycle, the set wins, so no event is lost.
- Level source i (mode[i] = 0):
  - pending[i] = irq_in[i], registered every cycle.
  - W1C writes and claims have no effect; the source must be cleared at the peripheral (e.g. timer status write).
- Pending is updated regardless of enable. Enable only gates the output and the claim.
- active = pending & enable.
- irq = |active, registered: asserted one cycle after active becomes nonzero, deasserted one cycle after it becomes zero.
- Register map; readdata is registered, 1-cycle latency, updated every cycle from the read mux, unused bits 0:
  - 0 PENDING: read pending. Write is W1C on edge-mode bits.
  - 1 ENABLE: read/write, writedata[NUM_IRQ-1:0].
  - 2 MODE: read/write. Writing a bit 0→1 also clears irq_d for that bit; a level already high then produces one edge the next cycle.
  - 3 CLAIM (read-only): [15] valid = |active; [3:0] = lowest index i with active[i] set, else 0.
    - A read with valid = 1 clears pending[i] if that source is edge mode, in the same cycle readdata captures the value.
    - The claim index is sampled from the active value present during the read cycle.
    - Writes to address 3 are ignored.
  - 4 RAW: read irq_in.
  - 5–7: read 0, writes ignored.
- Simultaneous W1C to address 0 and a claim cannot occur, since there is a single port.
- A write to ENABLE and a new rise in the same cycle: the pending set still occurs.
- Reset mid-operation clears all pending immediately (asynchronous). The first rising edge after release is detected relative to irq_d = 0, so any input already high at release registers as an edge.
- The NUM_IRQ < 16 tie-off reads 0 in all register bits at and above NUM_IRQ.

Test Plan:
- Reset values:
  - Stimulus: hold reset with irq_in = 8'hFF, then release and read addresses 0–4.
  - Required: PENDING = 0x0000 at release; irq = 0; ENABLE = 0x0000; MODE = 0x0000; RAW = 0x00FF.
- Edge latch and W1C:
  - Stimulus: MODE = 0x0001, ENABLE = 0x0001; pulse irq_in[0] for 1 cycle.
  - Required: irq = 1 two cycles after the pulse; PENDING reads 0x0001.
  - Stimulus: write 0x0001 to address 0.
  - Required: irq = 0 two cycles after the write.
- Priority claim:
  - Stimulus: MODE = 0x00FF, ENABLE = 0x00FF; pulse bits 5 and 2 together.
  - Required: first CLAIM read = 0x8002, second = 0x8005, third = 0x0000; irq drops after the second claim.
- Level mode:
  - Stimulus: MODE = 0, ENABLE = 0x0004; hold irq_in[2] high, then claim.
  - Required: CLAIM = 0x8002 repeatedly; PENDING stays 0x0004 until irq_in[2] falls; irq follows the input with 2-cycle lag.
- Set-beats-clear:
  - Stimulus: edge mode on bit 3; issue a W1C 0x0008 in the same cycle as a new rise on bit 3.
  - Required: PENDING stays 0x0008.
- Masking:
  - Stimulus: ENABLE = 0; pulse an edge on bit 1.
  - Required: irq stays 0; PENDING = 0x0002; CLAIM = 0x0000.
  - Stimulus: set ENABLE = 0x0002.
  - Required: irq = 1 within 2 cycles.

Source files
------------

// File: rtl/limbus_irq_ctrl.sv
// Prioritised interrupt controller for limbus peripherals, with edge/level latching, enable mask and claim.
// Latency: irq follows the pending & enable state by one cycle; readdata is registered with one cycle of latency.
// Backpressure: none; the Avalon slave completes every access in a single cycle.
module limbus_irq_ctrl #(
   parameter int          NUM_IRQ    = 8,
   parameter logic [15:0] RST_ENABLE = 16'h0000,
   parameter logic [15:0] RST_MODE   = 16'h0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   output logic               irq
);

   // Mask of the NUM_IRQ source bits; every register bit outside it reads as zero.
   localparam logic [15:0] IRQ_MASK = 16'((32'h1 << NUM_IRQ) - 32'h1);

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_ENABLE  = 3'd1;
   localparam logic [2:0] ADDR_MODE    = 3'd2;
   localparam logic [2:0] ADDR_CLAIM   = 3'd3;
   localparam logic [2:0] ADDR_RAW     = 3'd4;

   // Architectural state, all kept 16 bits wide with unimplemented bits held at zero.
   logic [15:0] pending_q,  pending_d;
   logic [15:0] irq_prev_q, irq_prev_d;
   logic [15:0] enable_q,   enable_d;
   logic [15:0] mode_q,     mode_d;
   logic [15:0] readdata_q, readdata_d;
   logic        irq_q,      irq_d;

   // Decoded bus strobes and derived vectors.
   logic        wr;
   logic        rd;
   logic [15:0] irq_ext;
   logic [15:0] rise;
   logic [15:0] active;
   logic        claim_vld;
   logic [3:0]  claim_idx;
   logic        claim_fire;
   logic [15:0] claim_clr;
   logic [15:0] w1c_clr;
   logic [15:0] mode_set;
   logic [15:0] edge_next;

   assign wr      = chipselect && !write_n;
   assign rd      = chipselect && write_n;
   assign irq_ext = 16'(irq_in) & IRQ_MASK;
   assign rise    = irq_ext & ~irq_prev_q;
   assign active  = pending_q & enable_q;

   // Claim selects the lowest-numbered active source; bit 0 has highest priority.
   always_comb begin
      claim_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (active[i]) begin
            claim_idx = 4'(i);
         end
      end
   end

   assign claim_vld  = |active;
   assign claim_fire = rd && (address == ADDR_CLAIM) && claim_vld;
   assign claim_clr  = claim_fire ? (16'h0001 << claim_idx) : 16'h0000;

   assign w1c_clr  = (wr && (address == ADDR_PENDING)) ? (writedata & IRQ_MASK) : 16'h0000;

   // Bits being switched from level to edge mode in this write.
   assign mode_set = (wr && (address == ADDR_MODE)) ? (writedata & ~mode_q & IRQ_MASK) : 16'h0000;

   // Edge bits: clears apply first and a coincident rise re-sets, so no event is lost.
   assign edge_next = (pending_q & ~(w1c_clr | claim_clr)) | rise;

   // Pending update: edge bits latch, level bits mirror the input, independent of enable.
   always_comb begin
      pending_d = ((mode_q & edge_next) | (~mode_q & irq_ext)) & IRQ_MASK;
   end

   // Edge history; forcing it low when a bit enters edge mode turns an already-high level into one edge.
   always_comb begin
      irq_prev_d = irq_ext & ~mode_set;
   end

   // Enable and mode register writes.
   always_comb begin
      enable_d = enable_q;
      mode_d   = mode_q;
      if (wr && (address == ADDR_ENABLE)) begin
         enable_d = writedata & IRQ_MASK;
      end
      if (wr && (address == ADDR_MODE)) begin
         mode_d = writedata & IRQ_MASK;
      end
   end

   // Read mux, captured every cycle so readdata always reflects the address of the previous cycle.
   always_comb begin
      readdata_d = 16'h0000;
      case (address)
         ADDR_PENDING: readdata_d = pending_q;
         ADDR_ENABLE:  readdata_d = enable_q;
         ADDR_MODE:    readdata_d = mode_q;
         ADDR_CLAIM:   readdata_d = {claim_vld, 11'd0, claim_idx};
         ADDR_RAW:     readdata_d = irq_ext;
         default:      readdata_d = 16'h0000;
      endcase
   end

   // Combined CPU interrupt, registered for a clean single-cycle lag.
   always_comb begin
      irq_d = |active;
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q  <= 16'h0000;
         irq_prev_q <= 16'h0000;
         enable_q   <= RST_ENABLE & IRQ_MASK;
         mode_q     <= RST_MODE & IRQ_MASK;
         readdata_q <= 16'h0000;
         irq_q      <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         irq_prev_q <= irq_prev_d;
         enable_q   <= enable_d;
         mode_q     <= mode_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_limbus_irq_ctrl.sv
// Self-checking bench for limbus_irq_ctrl.
// Reads push their expected readdata into a scoreboard; a monitor compares one cycle later.
// irq is checked directly at hand-computed cycles; all sampling happens on the falling edge.
module tb_limbus_irq_ctrl;

   logic        clk;
   logic        reset;
   logic [7:0]  irq_in;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] exp_q[$];
   string       name_q[$];
   logic        rsp_vld;

   limbus_irq_ctrl #(
      .NUM_IRQ    (8),
      .RST_ENABLE (16'h0000),
      .RST_MODE   (16'h0000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A read in progress at a rising edge produces a response visible at the next falling edge.
   always @(posedge clk) begin
      rsp_vld <= !reset && chipselect && write_n;
   end

   // Monitor: pop the expected value for every response the DUT presents.
   always @(negedge clk) begin
      if (rsp_vld) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read: readdata=0x%04h with no expectation", readdata);
         end else begin
            logic [15:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (readdata !== e) begin
               n_fail++;
               $display("FAIL %s: readdata=0x%04h expected=0x%04h", nm, readdata, e);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%04h expected=0x%04h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_rd(input logic [2:0] a, input logic [15:0] exp, input string nm);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(negedge clk);
      chipselect = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      irq_in     = 8'hFF;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 16'h0000;
      repeat (3) tick();
      chk("reset_readdata", readdata, 16'h0000);
      chk("reset_irq", {15'd0, irq}, 16'h0000);

      // Reset values; pending still zero in the first cycle after release.
      reset = 1'b0;
      bus_rd(3'd0, 16'h0000, "rst_pending");
      chk("rst_irq_after", {15'd0, irq}, 16'h0000);
      bus_rd(3'd1, 16'h0000, "rst_enable");
      bus_rd(3'd2, 16'h0000, "rst_mode");
      bus_rd(3'd4, 16'h00FF, "rst_raw");
      bus_rd(3'd5, 16'h0000, "addr5_zero");
      irq_in = 8'h00;
      repeat (2) tick();

      // Edge latch and W1C.
      bus_wr(3'd2, 16'h0001);
      bus_wr(3'd1, 16'h0001);
      irq_in = 8'h01;
      tick();
      irq_in = 8'h00;
      chk("edge_irq_lag1", {15'd0, irq}, 16'h0000);
      tick();
      chk("edge_irq_set", {15'd0, irq}, 16'h0001);
      bus_rd(3'd0, 16'h0001, "edge_pending");
      bus_wr(3'd0, 16'h0001);
      chk("w1c_irq_lag1", {15'd0, irq}, 16'h0001);
      tick();
      chk("w1c_irq_clr", {15'd0, irq}, 16'h0000);

      // Priority claim, plus enable tie-off and ignored claim write.
      bus_wr(3'd2, 16'h00FF);
      bus_wr(3'd1, 16'hFFFF);
      bus_rd(3'd1, 16'h00FF, "enable_tieoff");
      bus_wr(3'd3, 16'hFFFF);
      irq_in = 8'h24;
      tick();
      irq_in = 8'h00;
      tick();
      bus_rd(3'd0, 16'h0024, "prio_pending");
      bus_rd(3'd3, 16'h8002, "claim_first");
      chk("claim_irq_1", {15'd0, irq}, 16'h0001);
      bus_rd(3'd3, 16'h8005, "claim_second");
      chk("claim_irq_2", {15'd0, irq}, 16'h0001);
      bus_rd(3'd3, 16'h0000, "claim_third");
      chk("claim_irq_drop", {15'd0, irq}, 16'h0000);

      // Level mode: claims and W1C do not clear, irq follows input with 2-cycle lag.
      bus_wr(3'd2, 16'h0000);
      bus_wr(3'd1, 16'h0004);
      irq_in = 8'h04;
      tick();
      chk("lvl_irq_lag1", {15'd0, irq}, 16'h0000);
      tick();
      chk("lvl_irq_set", {15'd0, irq}, 16'h0001);
      bus_rd(3'd3, 16'h8002, "lvl_claim_1");
      bus_rd(3'd3, 16'h8002, "lvl_claim_2");
      bus_wr(3'd0, 16'h0004);
      bus_rd(3'd0, 16'h0004, "lvl_pending");
      irq_in = 8'h00;
      tick();
      chk("lvl_irq_fall_lag1", {15'd0, irq}, 16'h0001);
      tick();
      chk("lvl_irq_fall", {15'd0, irq}, 16'h0000);
      bus_rd(3'd0, 16'h0000, "lvl_pending_clr");

      // Set beats clear on an edge source.
      bus_wr(3'd2, 16'h0008);
      bus_wr(3'd1, 16'h0008);
      irq_in = 8'h08;
      tick();
      irq_in = 8'h00;
      tick();
      irq_in = 8'h08;
      bus_wr(3'd0, 16'h0008);
      irq_in = 8'h00;
      bus_rd(3'd0, 16'h0008, "set_beats_clr");
      bus_wr(3'd0, 16'h0008);
      bus_rd(3'd0, 16'h0000, "w1c_plain");

      // Masking: pending latches while disabled, claim shows nothing.
      bus_wr(3'd1, 16'h0000);
      bus_wr(3'd2, 16'h0002);
      irq_in = 8'h02;
      tick();
      irq_in = 8'h00;
      repeat (2) tick();
      chk("mask_irq_off", {15'd0, irq}, 16'h0000);
      bus_rd(3'd0, 16'h0002, "mask_pending");
      bus_rd(3'd3, 16'h0000, "mask_claim");
      bus_rd(3'd0, 16'h0002, "mask_pending_kept");
      bus_wr(3'd1, 16'h0002);
      chk("unmask_irq_lag1", {15'd0, irq}, 16'h0000);
      tick();
      chk("unmask_irq_set", {15'd0, irq}, 16'h0001);

      // Asynchronous reset mid-operation.
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_irq", {15'd0, irq}, 16'h0000);
      chk("async_rst_rdata", readdata, 16'h0000);
      tick();
      reset = 1'b0;
      bus_rd(3'd0, 16'h0000, "post_rst_pending");
      bus_rd(3'd1, 16'h0000, "post_rst_enable");

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d reads never answered", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
